// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Central stall/flush controller for a five-stage in-order pipeline. It
// arbitrates three hazard sources with fixed priority:
//   1. EX multi-cycle unit busy (ex_bubble_req): freeze PC, IF/ID and ID/EX
//      and push a bubble into EX/MEM.
//   2. Branch/jump taken (branch_taken): flush IF/ID and ID/EX. A branch that
//      resolves while EX is frozen is held pending and applied in the first
//      unfrozen cycle.
//   3. Load-use hazard (load_use): hold PC and IF/ID for one cycle and inject a
//      NOP into ID/EX.
// All control outputs are combinational from the current state and inputs, so
// the response to ex_bubble_req is zero-cycle.
//
// A watchdog counts consecutive EX stall cycles and raises a sticky
// stall_timeout when a stall runs longer than MAX_STALL cycles.
//
// Optional feature macro: PIPE_STALL_PERF_CNT_EN
//   defined   -> stall_cycles / flush_count are saturating performance counters
//   undefined -> both outputs are tied to zero and no counter flops exist
//
// Parameters
//   MAX_STALL  longest legal continuous EX stall in cycles (2..255)
//   CNT_W      width of the performance counters
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous, active-high reset
//   ex_bubble_req  in   EX multi-cycle unit busy
//   branch_taken   in   branch/jump resolved taken in EX this cycle
//   load_use       in   ID instruction depends on a load in EX
//   pc_en          out  PC update enable
//   if_id_en       out  IF/ID update enable
//   id_ex_en       out  ID/EX update enable
//   if_id_flush    out  load NOP into IF/ID
//   id_ex_flush    out  load NOP into ID/EX
//   ex_mem_bubble  out  load NOP into EX/MEM
//   stall_timeout  out  sticky watchdog error flag
//   stall_cycles   out  number of cycles with ex_bubble_req=1 (saturating)
//   flush_count    out  number of applied branch flushes (saturating)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_bubble_req,
  input  logic             branch_taken,
  input  logic             load_use,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Watchdog threshold widened to match the 9-bit incremented run length, so
  // a saturated 8-bit run length still compares correctly for MAX_STALL=255.
  localparam logic [8:0] MaxStallW = 9'(MAX_STALL);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StExStall   = 2'd1,
    StFlushPend = 2'd2
  } state_e;

  state_e     r_state;
  state_e     w_state_next;

  logic [7:0] r_run_len;
  logic [8:0] w_run_inc;
  logic       r_stall_timeout;

  logic       w_pend;
  logic       w_flush_apply;
  logic       w_load_hold;

  // -------------------------------------------------------------------------
  // Event decode
  // -------------------------------------------------------------------------
  assign w_pend = (r_state == StFlushPend);

  // A flush happens only in a cycle where EX is not frozen; a pending branch
  // and a live branch merge into a single flush.
  assign w_flush_apply = !rst && !ex_bubble_req && (w_pend || branch_taken);

  // Load-use hold only when nothing of higher priority is active.
  assign w_load_hold = !rst && !ex_bubble_req && !w_pend && !branch_taken && load_use;

  // -------------------------------------------------------------------------
  // Control outputs (combinational)
  // -------------------------------------------------------------------------
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;

    if (rst) begin
      // Hold the front end and keep NOPs flowing into IF/ID and ID/EX.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_bubble_req) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (w_flush_apply) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_hold) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = StRun;
    case (r_state)
      StRun, StExStall: begin
        if (ex_bubble_req) begin
          w_state_next = branch_taken ? StFlushPend : StExStall;
        end else begin
          w_state_next = StRun;
        end
      end
      StFlushPend: begin
        // Further branches while pending are absorbed; one flush only.
        w_state_next = ex_bubble_req ? StFlushPend : StRun;
      end
      default: w_state_next = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Stall watchdog
  // -------------------------------------------------------------------------
  assign w_run_inc = {1'b0, r_run_len} + 9'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_len <= 8'd0;
    end else if (!ex_bubble_req) begin
      r_run_len <= 8'd0;
    end else if (r_run_len != 8'hFF) begin
      r_run_len <= w_run_inc[7:0];
    end
  end

  // Set on the edge where the run length first exceeds MAX_STALL, so the flag
  // is visible in the cycle after the (MAX_STALL+1)th stall cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_timeout <= 1'b0;
    end else if (ex_bubble_req && (w_run_inc > MaxStallW)) begin
      r_stall_timeout <= 1'b1;
    end
  end

  assign stall_timeout = r_stall_timeout;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef PIPE_STALL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (ex_bubble_req && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush_apply && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  localparam int unsigned MaxStall = 8;
  localparam int unsigned CntW     = 6;
  localparam int          CntMax   = (1 << CntW) - 1;
`ifdef PIPE_STALL_PERF_CNT_EN
  localparam int          PerfEn   = 1;
`else
  localparam int          PerfEn   = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ex_bubble_req = 1'b0;
  logic            branch_taken = 1'b0;
  logic            load_use = 1'b0;
  logic            pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble;
  logic            stall_timeout;
  logic [CntW-1:0] stall_cycles, flush_count;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_stall_ctrl #(
    .MAX_STALL(MaxStall),
    .CNT_W    (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_bubble_req(ex_bubble_req),
    .branch_taken (branch_taken),
    .load_use     (load_use),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_bubble(ex_mem_bubble),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pending-branch bit, a stall run length, and plain
  // integer event counts. Checked on every falling edge.
  bit m_pend  = 1'b0;
  int m_run   = 0;
  bit m_to    = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  always @(negedge clk) begin
    bit e_pc, e_ifid, e_idex, e_iff, e_idf, e_emb, flush_now;
    flush_now = !rst && !ex_bubble_req && (m_pend || branch_taken);
    if (rst) begin
      {e_pc, e_ifid, e_idex, e_iff, e_idf, e_emb} = 6'b000110;
    end else if (ex_bubble_req) begin
      {e_pc, e_ifid, e_idex, e_iff, e_idf, e_emb} = 6'b000001;
    end else if (flush_now) begin
      {e_pc, e_ifid, e_idex, e_iff, e_idf, e_emb} = 6'b111110;
    end else if (load_use) begin
      {e_pc, e_ifid, e_idex, e_iff, e_idf, e_emb} = 6'b001010;
    end else begin
      {e_pc, e_ifid, e_idex, e_iff, e_idf, e_emb} = 6'b111000;
    end
    chk("m_pc_en", pc_en, e_pc);
    chk("m_if_id_en", if_id_en, e_ifid);
    chk("m_id_ex_en", id_ex_en, e_idex);
    chk("m_if_id_flush", if_id_flush, e_iff);
    chk("m_id_ex_flush", id_ex_flush, e_idf);
    chk("m_ex_mem_bubble", ex_mem_bubble, e_emb);
    chk("m_stall_timeout", stall_timeout, m_to);
    chk("m_stall_cycles", stall_cycles, PerfEn ? m_stall : 0);
    chk("m_flush_count", flush_count, PerfEn ? m_flush : 0);

    if (rst) begin
      m_pend = 0; m_run = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (ex_bubble_req && m_stall < CntMax) m_stall++;
      if (flush_now && m_flush < CntMax) m_flush++;
      m_run = ex_bubble_req ? m_run + 1 : 0;
      if (m_run > MaxStall) m_to = 1;
      m_pend = ex_bubble_req && (m_pend || branch_taken);
    end
  end

  // Apply one cycle of inputs just after the rising edge; return at the
  // following falling edge so outputs for that cycle can be inspected.
  task automatic drive(input logic r, input logic b, input logic br, input logic lu);
    @(posedge clk);
    #1;
    rst = r; ex_bubble_req = b; branch_taken = br; load_use = lu;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
  endtask

  int burst;

  initial begin
    do_reset();
    chk("rst_pc_en", pc_en, 0);
    chk("rst_if_id_flush", if_id_flush, 1);
    chk("rst_id_ex_flush", id_ex_flush, 1);
    chk("rst_ex_mem_bubble", ex_mem_bubble, 0);
    drive(0, 0, 0, 0);
    chk("idle_pc_en", pc_en, 1);
    chk("idle_if_id_en", if_id_en, 1);
    chk("idle_timeout", stall_timeout, 0);
    chk("idle_stall_cycles", stall_cycles, 0);

    // Three-cycle EX stall from RUN.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      chk("stall3_pc_en", pc_en, 0);
      chk("stall3_id_ex_en", id_ex_en, 0);
      chk("stall3_ex_mem_bubble", ex_mem_bubble, 1);
    end
    drive(0, 0, 0, 0);
    chk("stall3_rel_pc_en", pc_en, 1);
    chk("stall3_rel_id_ex_en", id_ex_en, 1);
    chk("stall3_rel_bubble", ex_mem_bubble, 0);
    chk("stall3_stall_cycles", stall_cycles, PerfEn ? 3 : 0);

    // Branch during stall is deferred to the release cycle.
    do_reset();
    drive(0, 1, 1, 0);
    chk("pend_c0_if_id_flush", if_id_flush, 0);
    drive(0, 1, 0, 0);
    chk("pend_c1_id_ex_flush", id_ex_flush, 0);
    drive(0, 0, 0, 0);
    chk("pend_c2_if_id_flush", if_id_flush, 1);
    chk("pend_c2_id_ex_flush", id_ex_flush, 1);
    chk("pend_c2_pc_en", pc_en, 1);
    drive(0, 0, 0, 0);
    chk("pend_c3_no_flush", if_id_flush, 0);
    chk("pend_flush_count", flush_count, PerfEn ? 1 : 0);

    // Repeated branch while pending yields a single flush.
    do_reset();
    drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    drive(0, 0, 0, 0);
    chk("dbl_flush_now", if_id_flush, 1);
    drive(0, 0, 0, 0);
    chk("dbl_no_second", if_id_flush, 0);
    chk("dbl_flush_count", flush_count, PerfEn ? 1 : 0);

    // Branch beats load-use; load-use alone holds the front end.
    drive(0, 0, 1, 1);
    chk("br_lu_pc_en", pc_en, 1);
    chk("br_lu_if_id_en", if_id_en, 1);
    chk("br_lu_if_id_flush", if_id_flush, 1);
    drive(0, 0, 0, 1);
    chk("lu_pc_en", pc_en, 0);
    chk("lu_if_id_en", if_id_en, 0);
    chk("lu_id_ex_en", id_ex_en, 1);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    chk("lu_if_id_flush", if_id_flush, 0);

    // Watchdog: exactly MAX_STALL is legal, one more trips it.
    do_reset();
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    chk("wd_8_no_timeout", stall_timeout, 0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, 0);
      if (i == 8) chk("wd_9th_cycle_low", stall_timeout, 0);
    end
    drive(0, 0, 0, 0);
    chk("wd_rise", stall_timeout, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("wd_sticky", stall_timeout, 1);
    do_reset();
    chk("wd_cleared", stall_timeout, 0);

    // Reset during a pending flush abandons it.
    drive(0, 1, 1, 0);
    drive(0, 1, 0, 0);
    drive(1, 1, 0, 0);
    drive(0, 0, 0, 0);
    chk("rstpend_if_id_flush", if_id_flush, 0);
    chk("rstpend_pc_en", pc_en, 1);
    chk("rstpend_flush_count", flush_count, 0);
    chk("rstpend_stall_cycles", stall_cycles, 0);

    // Randomized traffic with occasional long bursts and rare resets.
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      logic r, b, br, lu;
      if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(6, 12);
      r  = ($urandom_range(0, 199) == 0);
      b  = (burst > 0) ? 1'b1 : ($urandom_range(0, 99) < 35);
      br = ($urandom_range(0, 99) < 20);
      lu = ($urandom_range(0, 99) < 25);
      if (burst > 0) burst--;
      drive(r, b, br, lu);
    end

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
